// File: rtl/axis_slave_if_pkg.sv
// Shared constants and types for the AXI-Stream input front end of the FFT
// accelerator.
//   S_TDATA_WDT      : AXIS beat width (must be >= C_SAMPLE_WDT)
//   C_SAMPLE_WDT     : width of one sample component (re or im)
//   C_FFT_SIZE_LOG2  : log2 of complex samples per frame
//   S_FIFO_DEPTH     : sample FIFO depth (power of 2, >= 2)
//   S_FIFO_ADDR_WDT  : FIFO address width
//   INPUT_MEM_OFFSET : first input memory address of a frame
//   S_BEATS_FINAL    : index of the last beat of a frame (two beats per sample)
//   s_rx_state       : receive FSM states
package axis_slave_if_pkg;

   localparam int S_TDATA_WDT      = 32;
   localparam int C_SAMPLE_WDT     = 18;
   localparam int C_FFT_SIZE_LOG2  = 10;
   localparam int C_FFT_SIZE       = 1 << C_FFT_SIZE_LOG2;
   localparam int S_FIFO_DEPTH     = 4;
   localparam int S_FIFO_ADDR_WDT  = $clog2(S_FIFO_DEPTH);
   localparam int INPUT_MEM_OFFSET = 0;
   localparam int S_BEATS_FINAL    = 2 * C_FFT_SIZE - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_DRAIN = 2'd2
   } s_rx_state;

endpackage

// File: rtl/axis_slave_if_fifo.sv
// Small synchronous FIFO holding packed {re, im} samples.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous pointer clear (frame start)
//   wr_en      : write wr_data (caller guarantees !full)
//   rd_en      : pop head (caller guarantees !empty)
//   rd_data    : head entry, combinational
//   full/empty : occupancy flags
// Pointers are one bit wider than the address so full and empty are
// distinguishable without a separate count.
module sync_fifo #(
   parameter int WDT   = 36,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           wr_en,
   input  logic [WDT-1:0] wr_data,
   input  logic           rd_en,
   output logic [WDT-1:0] rd_data,
   output logic           full,
   output logic           empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [WDT-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = ((wr_ptr - rd_ptr) == PTR_DEPTH);

`ifndef SYNTHESIS
   a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));
   a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty));
`endif

endmodule

// File: rtl/axis_slave_if.sv
// AXI-Stream slave front end of the FFT accelerator. Receives one frame of
// C_FFT_SIZE complex samples (two beats each: real, then imaginary), narrows
// each beat to C_SAMPLE_WDT bits, buffers packed samples in a small FIFO and
// writes them sequentially into the input sample memory.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   S_AXIS_TDATA/TLAST/
//   TVALID/TREADY         : AXI-Stream slave; low C_SAMPLE_WDT bits of TDATA used
//   s_axis_if_addr        : input memory write address
//   data_re_0_in/_im_0_in : sample written to memory
//   push                  : memory write strobe
//   mem_stall             : memory busy, holds FIFO pops
//   rx_start              : core grants input memory, starts a frame (S_IDLE only)
//   rx_done               : one-cycle pulse after the last memory write
//   rx_err                : sticky TLAST framing error, cleared by rx_start
//   s_axis_if_busy        : frame in progress or FIFO holding data
//   rx_state              : current FSM state, for observation
// Handshake: a beat transfers on a rising clk edge where TVALID & TREADY.
// TREADY is computed from internal state only and never looks at TVALID;
// the source must hold TDATA/TLAST stable while TVALID is high and unaccepted.
module axis_slave_if
   import axis_slave_if_pkg::*;
#(
   parameter int S_TDATA_WDT      = axis_slave_if_pkg::S_TDATA_WDT,
   parameter int C_SAMPLE_WDT     = axis_slave_if_pkg::C_SAMPLE_WDT,
   parameter int C_FFT_SIZE_LOG2  = axis_slave_if_pkg::C_FFT_SIZE_LOG2,
   parameter int S_FIFO_DEPTH     = axis_slave_if_pkg::S_FIFO_DEPTH,
   parameter int INPUT_MEM_OFFSET = axis_slave_if_pkg::INPUT_MEM_OFFSET
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [S_TDATA_WDT-1:0]     S_AXIS_TDATA,
   input  logic                       S_AXIS_TLAST,
   input  logic                       S_AXIS_TVALID,
   output logic                       S_AXIS_TREADY,
   output logic [C_FFT_SIZE_LOG2-1:0] s_axis_if_addr,
   output logic [C_SAMPLE_WDT-1:0]    data_re_0_in,
   output logic [C_SAMPLE_WDT-1:0]    data_im_0_in,
   output logic                       push,
   input  logic                       mem_stall,
   input  logic                       rx_start,
   output logic                       rx_done,
   output logic                       rx_err,
   output logic                       s_axis_if_busy,
   output s_rx_state                  rx_state
);

   localparam int AW   = C_FFT_SIZE_LOG2;
   localparam int BCW  = C_FFT_SIZE_LOG2 + 1;
   localparam int FW   = 2 * C_SAMPLE_WDT;
   localparam logic [BCW-1:0] BEAT_FINAL = {BCW{1'b1}};   // 2*C_FFT_SIZE-1
   localparam logic [AW-1:0]  ADDR_BASE  = AW'(INPUT_MEM_OFFSET);

   s_rx_state               state;
   logic [BCW-1:0]          beat_cnt;
   logic                    phase;           // 0: expecting re, 1: expecting im
   logic                    all_beats_rcvd;
   logic [C_SAMPLE_WDT-1:0] re_q;

   logic                    hs;
   logic                    last_beat;
   logic                    tlast_bad;
   logic [C_SAMPLE_WDT-1:0] tdata_s;

   logic                    fifo_clr;
   logic                    fifo_wr;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [FW-1:0]           fifo_rd_data;

   // Upper TDATA bits are truncated away by design.
   assign tdata_s = S_AXIS_TDATA[C_SAMPLE_WDT-1:0];
   generate
      if (S_TDATA_WDT > C_SAMPLE_WDT) begin : g_unused_tdata
         logic unused_tdata_hi;
         assign unused_tdata_hi = ^S_AXIS_TDATA[S_TDATA_WDT-1:C_SAMPLE_WDT];
      end
   endgenerate

   assign S_AXIS_TREADY = (state == S_RECV) && !fifo_full && !all_beats_rcvd;
   assign hs            = S_AXIS_TVALID && S_AXIS_TREADY;
   assign last_beat     = (beat_cnt == BEAT_FINAL);
   assign tlast_bad     = (S_AXIS_TLAST != last_beat);

   assign fifo_clr = (state == S_IDLE) && rx_start;
   assign fifo_wr  = hs && phase;
   assign fifo_pop = !fifo_empty && !mem_stall;

   sync_fifo #(
      .WDT   (FW),
      .DEPTH (S_FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (fifo_clr),
      .wr_en   (fifo_wr),
      .wr_data ({re_q, tdata_s}),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         beat_cnt       <= '0;
         phase          <= 1'b0;
         all_beats_rcvd <= 1'b0;
         re_q           <= '0;
         rx_err         <= 1'b0;
         rx_done        <= 1'b0;
         push           <= 1'b0;
         data_re_0_in   <= '0;
         data_im_0_in   <= '0;
         s_axis_if_addr <= ADDR_BASE;
      end else begin
         rx_done <= 1'b0;

         // Memory side: the pop of one cycle becomes the push of the next.
         push <= fifo_pop;
         if (fifo_pop) begin
            data_re_0_in <= fifo_rd_data[FW-1:C_SAMPLE_WDT];
            data_im_0_in <= fifo_rd_data[C_SAMPLE_WDT-1:0];
         end
         if (push) s_axis_if_addr <= s_axis_if_addr + AW'(1);

         case (state)
            S_IDLE: begin
               if (rx_start) begin
                  state          <= S_RECV;
                  beat_cnt       <= '0;
                  phase          <= 1'b0;
                  all_beats_rcvd <= 1'b0;
                  rx_err         <= 1'b0;
                  s_axis_if_addr <= ADDR_BASE;
               end
            end
            S_RECV: begin
               if (hs) begin
                  phase    <= ~phase;
                  beat_cnt <= beat_cnt + BCW'(1);
                  if (!phase)   re_q   <= tdata_s;
                  if (tlast_bad) rx_err <= 1'b1;
                  if (last_beat) begin
                     all_beats_rcvd <= 1'b1;
                     state          <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // All samples are already in the FIFO on entry, so an empty
               // FIFO with push high means the final memory write is happening.
               if (fifo_empty && push) begin
                  state   <= S_IDLE;
                  rx_done <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign s_axis_if_busy = (state != S_IDLE) || !fifo_empty;
   assign rx_state       = state;

`ifndef SYNTHESIS
   logic [BCW-1:0] push_cnt;
   always_ff @(posedge clk) begin
      if (!rst_n || fifo_clr) push_cnt <= '0;
      else if (push)          push_cnt <= push_cnt + BCW'(1);
   end

   a_no_tready_idle: assert property (@(posedge clk) disable iff (!rst_n)
      (state == S_IDLE) |-> !S_AXIS_TREADY);
   a_push_count: assert property (@(posedge clk) disable iff (!rst_n)
      rx_done |-> (push_cnt == BCW'(1 << C_FFT_SIZE_LOG2)));
`endif

endmodule

// File: tb/tb_axis_slave_if.sv
module tb_axis_slave_if;
  import axis_slave_if_pkg::*;

  localparam int TW     = 32;
  localparam int SW     = 18;
  localparam int LOG2   = 3;
  localparam int N      = 1 << LOG2;
  localparam int BEATS  = 2 * N;
  localparam int DEPTH  = 4;
  localparam int OFFSET = 0;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [TW-1:0]   S_AXIS_TDATA  = '0;
  logic            S_AXIS_TLAST  = 1'b0;
  logic            S_AXIS_TVALID = 1'b0;
  logic            S_AXIS_TREADY;
  logic [LOG2-1:0] s_axis_if_addr;
  logic [SW-1:0]   data_re_0_in;
  logic [SW-1:0]   data_im_0_in;
  logic            push;
  logic            mem_stall = 1'b0;
  logic            rx_start  = 1'b0;
  logic            rx_done;
  logic            rx_err;
  logic            s_axis_if_busy;
  s_rx_state       dbg_state;

  axis_slave_if #(
    .S_TDATA_WDT      (TW),
    .C_SAMPLE_WDT     (SW),
    .C_FFT_SIZE_LOG2  (LOG2),
    .S_FIFO_DEPTH     (DEPTH),
    .INPUT_MEM_OFFSET (OFFSET)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .S_AXIS_TDATA   (S_AXIS_TDATA),
    .S_AXIS_TLAST   (S_AXIS_TLAST),
    .S_AXIS_TVALID  (S_AXIS_TVALID),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .s_axis_if_addr (s_axis_if_addr),
    .data_re_0_in   (data_re_0_in),
    .data_im_0_in   (data_im_0_in),
    .push           (push),
    .mem_stall      (mem_stall),
    .rx_start       (rx_start),
    .rx_done        (rx_done),
    .rx_err         (rx_err),
    .s_axis_if_busy (s_axis_if_busy),
    .rx_state       (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Stored component = beat value modulo 2**SW.
  function automatic logic [SW-1:0] trunc(input logic [TW-1:0] v);
    return v[SW-1:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [2*SW-1:0] exp_q[$];
  logic [2*SW-1:0] exp_s;
  int   cyc            = 0;
  int   push_idx       = 0;
  int   done_cnt       = 0;
  int   first_push_cyc = 0;
  int   im0_cyc        = 0;
  int   beats_acc      = 0;
  bit   frame_active   = 0;
  bit   prev_push      = 0;
  logic [SW-1:0] first_re = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (push) begin
        if (push_idx == 0) begin
          first_push_cyc = cyc;
          first_re       = data_re_0_in;
        end
        if (exp_q.size() == 0) check("push_unexpected", 1, 0);
        else begin
          exp_s = exp_q.pop_front();
          check("push_data", {data_re_0_in, data_im_0_in}, exp_s);
          check("push_addr", s_axis_if_addr, (OFFSET + push_idx) % N);
        end
        push_idx++;
      end
      if (rx_done) begin
        check("done_after_n_push", push_idx, N);
        check("done_follows_push", prev_push, 1);
        done_cnt++;
      end
      if (!frame_active || beats_acc >= BEATS) check("tready_low", S_AXIS_TREADY, 0);
      prev_push = push;
    end else begin
      prev_push = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic stall_proc();
    bit dropped = 0;
    for (int w = 0; w < 300 && push_idx < 3; w++) @(negedge clk);
    mem_stall = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!S_AXIS_TREADY) dropped = 1;
    end
    mem_stall = 1'b0;
    check("tready_drop_on_full", dropped, 1);
  endtask

  // data_mode: 0 re=k/im=-k, 1 random, 2 random with truncation pattern first
  task automatic send_frame(input int data_mode, input int gap_max, input int tlast_beat,
                            input bit do_stall, input int abort_after);
    logic [TW-1:0] td;
    logic [TW-1:0] re_td;
    bit ok;
    bit exp_err;
    int done0;
    int k;
    re_td   = '0;
    exp_err = (tlast_beat != BEATS - 1);
    @(negedge clk);
    push_idx     = 0;
    beats_acc    = 0;
    frame_active = 1;
    done0        = done_cnt;
    rx_start     = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    check("err_clear_on_start", rx_err, 0);
    check("busy_in_frame", s_axis_if_busy, 1);
    if (do_stall) fork stall_proc(); join_none
    for (int b = 0; b < BEATS; b++) begin
      if (b == abort_after) return;
      S_AXIS_TVALID = 1'b0;
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      k = b / 2;
      case (data_mode)
        0:       td = (b % 2 == 0) ? TW'(k) : TW'(-k);
        2:       td = (b == 0) ? 32'hFFFE_0003 : $urandom;
        default: td = $urandom;
      endcase
      S_AXIS_TDATA  = td;
      S_AXIS_TLAST  = (b == tlast_beat);
      S_AXIS_TVALID = 1'b1;
      ok = 0;
      for (int w = 0; w < 100; w++) begin
        if (S_AXIS_TREADY) begin
          ok = 1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) begin
        check("beat_accept_timeout", 0, 1);
        S_AXIS_TVALID = 1'b0;
        frame_active  = 0;
        return;
      end
      // Beat transfers at the coming rising edge.
      beats_acc++;
      if (b % 2 == 0) re_td = td;
      else begin
        exp_q.push_back({trunc(re_td), trunc(td)});
        if (k == 0) im0_cyc = cyc;
      end
      @(negedge clk);
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    for (int w = 0; w < 400; w++) begin
      if (done_cnt != done0) break;
      @(negedge clk);
    end
    check("rx_done_seen", done_cnt - done0, 1);
    repeat (3) @(negedge clk);
    if (do_stall) wait fork;
    check("rx_done_once", done_cnt - done0, 1);
    check("all_pushed", push_idx, N);
    check("exp_q_empty", exp_q.size(), 0);
    check("rx_err", rx_err, exp_err);
    check("first_push_latency", first_push_cyc - im0_cyc, 2);
    check("busy_after", s_axis_if_busy, 0);
    check("state_idle", dbg_state, S_IDLE);
    frame_active = 0;
    beats_acc    = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_tready", S_AXIS_TREADY, 0);
    check("rst_push", push, 0);
    check("rst_done", rx_done, 0);
    check("rst_err", rx_err, 0);
    check("rst_busy", s_axis_if_busy, 0);
    check("rst_addr", s_axis_if_addr, OFFSET);
    check("rst_data", {data_re_0_in, data_im_0_in}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(0, 0, BEATS - 1, 0, -1);           // nominal
    send_frame(0, 0, BEATS - 1, 1, -1);           // memory backpressure
    for (int f = 0; f < 3; f++)
      send_frame(1, 5, BEATS - 1, 0, -1);         // bursty source
    send_frame(1, 2, 7, 0, -1);                   // early TLAST
    send_frame(0, 0, BEATS - 1, 0, -1);           // error clears on next start
    send_frame(2, 1, BEATS - 1, 0, -1);           // truncation
    check("trunc_value", first_re, 18'h20003);

    // Reset in the middle of a frame.
    send_frame(1, 0, BEATS - 1, 0, 5);
    rst_n         = 1'b0;
    frame_active  = 0;
    beats_acc     = 0;
    S_AXIS_TVALID = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_tready", S_AXIS_TREADY, 0);
    check("midrst_push", push, 0);
    check("midrst_busy", s_axis_if_busy, 0);
    check("midrst_addr", s_axis_if_addr, OFFSET);
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(1, 3, BEATS - 1, 0, -1);           // fresh frame after reset

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
